// File: rtl/branch_pred_bht.sv
// Branch history table: 2**IDX_W two-bit saturating counters indexed by PC[IDX_W+1:2].
// A lookup gives a registered prediction code one cycle later. Resolved branches
// train the table. The block also keeps saturating lookup and misprediction counts.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   lookup_valid_i/pc_i  branch PC from fetch to predict
//   upd_valid_i/pc_i     resolved branch from execute
//   upd_taken_i          actual outcome (1 = taken)
//   upd_pred_taken_i     prediction that was issued for this branch
//   pred_o               00 none, 10 predict taken, 01 predict not-taken (11 never driven)
//   lookup_cnt_o         accepted lookups, saturating at all-ones
//   mispred_cnt_o        mispredicting updates, saturating at all-ones
module branch_pred_bht #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lookup_valid_i,
  input  logic [PC_W-1:0]  lookup_pc_i,
  input  logic             upd_valid_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_taken_i,
  output logic [1:0]       pred_o,
  output logic [CNT_W-1:0] lookup_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned Entries = 2 ** IDX_W;

  localparam logic [1:0] PredNone     = 2'b00;
  localparam logic [1:0] PredTaken    = 2'b10;
  localparam logic [1:0] PredNotTaken = 2'b01;
  localparam logic [1:0] CtrWeakNt    = 2'b01;

  logic [1:0]       ctr_q [Entries];
  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_new;
  logic [1:0]       lkp_val;
  logic [1:0]       pred_d, pred_q;
  logic [CNT_W-1:0] lookup_cnt_d, lookup_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;

  // PC bits outside the index field carry no information here (no tag check).
  logic unused_pc;
  assign unused_pc = ^{lookup_pc_i[PC_W-1:IDX_W+2], lookup_pc_i[1:0],
                       upd_pc_i[PC_W-1:IDX_W+2], upd_pc_i[1:0]};

  assign lkp_idx = lookup_pc_i[IDX_W+1:2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];

  // Trained value of the counter addressed by the update port.
  always_comb begin
    upd_cur = ctr_q[upd_idx];
    upd_new = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != 2'b11) upd_new = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_new = upd_cur - 2'd1;
    end
  end

  // Same-index update in the same cycle is forwarded so the lookup sees the trained value.
  always_comb begin
    lkp_val = ctr_q[lkp_idx];
    if (upd_valid_i && (upd_idx == lkp_idx)) lkp_val = upd_new;
  end

  always_comb begin
    pred_d = PredNone;
    if (lookup_valid_i) pred_d = lkp_val[1] ? PredTaken : PredNotTaken;
  end

  always_comb begin
    lookup_cnt_d = lookup_cnt_q;
    if (lookup_valid_i && (lookup_cnt_q != '1)) lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid_i && (upd_taken_i != upd_pred_taken_i) && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Entries; i++) ctr_q[i] <= CtrWeakNt;
    end else if (upd_valid_i) begin
      ctr_q[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_q        <= PredNone;
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pred_q        <= pred_d;
      lookup_cnt_q  <= lookup_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pred_o        = pred_q;
  assign lookup_cnt_o  = lookup_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_bht.sv
module tb_branch_pred_bht;

  localparam int IDX_W = 6;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int NENT  = 64;
  localparam int CMAX  = 15;

  logic             clk;
  logic             rst_n;
  logic             lookup_valid;
  logic [PC_W-1:0]  lookup_pc;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic             upd_pred_taken;
  logic [1:0]       pred;
  logic [CNT_W-1:0] lookup_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // Behavioural model: counters as plain integers 0..3 (>= 2 means predict taken).
  int m_ctr [NENT];
  int exp_pred;
  int exp_lk;
  int exp_mis;

  branch_pred_bht #(
    .IDX_W(IDX_W),
    .PC_W (PC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .lookup_valid_i  (lookup_valid),
    .lookup_pc_i     (lookup_pc),
    .upd_valid_i     (upd_valid),
    .upd_pc_i        (upd_pc),
    .upd_taken_i     (upd_taken),
    .upd_pred_taken_i(upd_pred_taken),
    .pred_o          (pred),
    .lookup_cnt_o    (lookup_cnt),
    .mispred_cnt_o   (mispred_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int pc_idx(input logic [PC_W-1:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_ctr[i] = 1;
    exp_pred = 0;
    exp_lk   = 0;
    exp_mis  = 0;
  endtask

  // Applies one clock of stimulus as the specification sees it: the update is
  // applied first, so a same-index lookup naturally observes the trained value.
  task automatic model_step(input bit lv, input logic [PC_W-1:0] lpc, input bit uv,
                            input logic [PC_W-1:0] upc, input bit ut, input bit upt);
    if (uv) begin
      int i = pc_idx(upc);
      if (ut) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      if ((ut != upt) && (exp_mis < CMAX)) exp_mis++;
    end
    if (lv) begin
      exp_pred = (m_ctr[pc_idx(lpc)] >= 2) ? 2 : 1;
      if (exp_lk < CMAX) exp_lk++;
    end else begin
      exp_pred = 0;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input bit lv, input logic [PC_W-1:0] lpc, input bit uv,
                       input logic [PC_W-1:0] upc, input bit ut, input bit upt);
    lookup_valid   = lv;
    lookup_pc      = lpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_pred_taken = upt;
    @(posedge clk);
    if (rst_n) model_step(lv, lpc, uv, upc, ut, upt);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Reset asserted mid-cycle, held across one edge, released away from the edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [PC_W-1:0] rand_pc();
    return PC_W'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) |
                 $urandom_range(0, 3));
  endfunction

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pred_model", int'(pred), exp_pred);
      check("lookup_cnt_model", int'(lookup_cnt), exp_lk);
      check("mispred_cnt_model", int'(mispred_cnt), exp_mis);
    end
  end

  initial begin
    rst_n          = 1'b0;
    lookup_valid   = 1'b0;
    lookup_pc      = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_pred_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pred", int'(pred), 0);
    check("reset_lookup_cnt", int'(lookup_cnt), 0);
    check("reset_mispred_cnt", int'(mispred_cnt), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Fresh counter is weak not-taken; the code lasts one cycle.
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("first_lookup_nt", int'(pred), 1);
    idle();
    check("first_lookup_clears", int'(pred), 0);
    check("first_lookup_cnt", int'(lookup_cnt), 1);

    // Two taken updates: 01 -> 11.
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("trained_taken", int'(pred), 2);
    idle();
    check("taken_one_cycle", int'(pred), 0);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("saturated_then_nt", int'(pred), 2);
    check("no_mispred_yet", int'(mispred_cnt), 0);

    // Bypass: same-cycle taken update on a 01 counter gives a taken prediction.
    mid_reset();
    cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
    check("bypass_pred", int'(pred), 2);
    check("bypass_mispred", int'(mispred_cnt), 1);

    // Aliasing: 0x140 shares the index of 0x40; 0x44 does not.
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1);
    cycle(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0);
    check("alias_taken", int'(pred), 2);
    cycle(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    check("neighbour_nt", int'(pred), 1);

    // Asynchronous reset between a lookup edge and the next edge.
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_pred", int'(pred), 2);
    lookup_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_pred", int'(pred), 0);
    check("async_reset_lookup_cnt", int'(lookup_cnt), 0);
    check("async_reset_mispred_cnt", int'(mispred_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    check("post_reset_ctr_weak_nt", int'(pred), 1);

    // Misprediction counter saturates at 15 and holds.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 32'h80, i[0], ~i[0]);
      if (i == 14) check("mispred_reaches_max", int'(mispred_cnt), 15);
    end
    check("mispred_holds", int'(mispred_cnt), 15);

    // Randomized traffic with occasional mid-operation resets.
    for (int n = 0; n < 4000; n++) begin
      bit lv, uv;
      logic [PC_W-1:0] lpc, upc;
      lv  = ($urandom_range(0, 3) != 0);
      uv  = ($urandom_range(0, 2) != 0);
      lpc = lv ? rand_pc() : PC_W'($urandom);
      upc = uv ? rand_pc() : PC_W'($urandom);
      cycle(lv, lpc, uv, upc, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 149) == 0) mid_reset();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
